// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of a shared Gray-to-binary converter.
// One word is captured per grant, converted, and held until the consumer accepts it.
module gray_conv_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] gray_in,
   output logic [NREQ-1:0]   gnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_bin,
   output logic [1:0]        out_id,
   output logic              busy,
   output logic [7:0]        conv_cnt
);

   localparam int IDW = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b      = {W{1'b0}};
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t            state_r;
   state_t            state_nx_s;
   logic              capture_s;
   logic              done_s;

   logic [IDW-1:0]    last_r;
   logic              win_found_s;
   logic [IDW-1:0]    win_idx_s;
   logic [IDW-1:0]    cand_s;
   logic [W-1:0]      win_word_s;
   logic [NREQ-1:0]   win_onehot_s;

   logic [NREQ-1:0]   gnt_r;
   logic              out_valid_r;
   logic              busy_r;
   logic [W-1:0]      word_r;
   logic [IDW-1:0]    id_r;
   logic [W-1:0]      out_bin_r;
   logic [7:0]        cnt_r;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {IDW{1'b0}};
      cand_s      = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         // IDW-bit addition wraps 3 -> 0 on its own.
         cand_s = last_r + IDW'(i + 1);
         if (!win_found_s && req[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Winner's word and one-hot grant vector.
   always_comb begin
      win_word_s   = {W{1'b0}};
      win_onehot_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx_s == IDW'(i)) begin
            win_word_s      = gray_in[i*W +: W];
            win_onehot_s[i] = win_found_s;
         end else begin
            win_onehot_s[i] = 1'b0;
         end
      end
   end

   // Next-state and control strobes.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_found_s) begin
               state_nx_s = CONV;
               capture_s  = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CONV: begin
            state_nx_s = OUT;
         end
         OUT: begin
            if (out_ready) begin
               state_nx_s = IDLE;
               done_s     = 1'b1;
            end else begin
               state_nx_s = OUT;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Status outputs are registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_r       <= {NREQ{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         gnt_r       <= capture_s ? win_onehot_s : {NREQ{1'b0}};
         out_valid_r <= (state_nx_s == OUT);
         busy_r      <= (state_nx_s != IDLE);
      end
   end

   // Capture of the winning word, its owner and the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r <= {W{1'b0}};
         id_r   <= {IDW{1'b0}};
         last_r <= IDW'(NREQ - 1);
      end else if (capture_s) begin
         word_r <= win_word_s;
         id_r   <= win_idx_s;
         last_r <= win_idx_s;
      end else begin
         word_r <= word_r;
         id_r   <= id_r;
         last_r <= last_r;
      end
   end

   // Conversion result, held until the next conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bin_r <= {W{1'b0}};
      end else if (state_r == CONV) begin
         out_bin_r <= gray2bin(word_r);
      end else begin
         out_bin_r <= out_bin_r;
      end
   end

   // Saturating handshake counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
      end else if (done_s && (cnt_r != 8'hFF)) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign gnt       = gnt_r;
   assign out_valid = out_valid_r;
   assign out_bin   = out_bin_r;
   assign out_id    = id_r;
   assign busy      = busy_r;
   assign conv_cnt  = cnt_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized and directed bench for gray_conv_arbiter against a transaction-level
// reference model (round-robin pick, XOR-of-shifts Gray decode, saturating count).
module tb_gray_conv_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] gray_in;
   logic [3:0]  gnt;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_bin;
   logic [1:0]  out_id;
   logic        busy;
   logic [7:0]  conv_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit         m_active;
   int         m_age;
   int         m_id;
   int         m_last;
   int         m_cnt;
   int         hs_count;
   logic [3:0] m_bin;
   logic [3:0] m_pend_bin;
   logic [3:0] m_gnt;
   int         dut_grants[$];

   always #5 clk = ~clk;

   gray_conv_arbiter #(.NREQ(4), .W(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .gnt(gnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
      .out_id(out_id), .busy(busy), .conv_cnt(conv_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit bit_of(input logic [3:0] v, input int i);
      logic [3:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic [3:0] word_of(input logic [15:0] g, input int i);
      logic [15:0] t;
      t = g >> (4 * i);
      return t[3:0];
   endfunction

   function automatic logic [3:0] ref_g2b(input logic [3:0] g);
      logic [3:0] b;
      b = 4'd0;
      for (int k = 0; k < 4; k++) b = b ^ (g >> k);
      return b;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_last   = 3;
      m_cnt    = 0;
      hs_count = 0;
      m_gnt    = 4'd0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [15:0] g, input logic rd);
      int w;
      w     = -1;
      m_gnt = 4'd0;
      if (!m_active) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (w < 0 && bit_of(r, c)) w = c;
         end
         if (w >= 0) begin
            m_active   = 1'b1;
            m_age      = 0;
            m_id       = w;
            m_pend_bin = ref_g2b(word_of(g, w));
            m_last     = w;
            m_gnt      = 4'd1 << w;
         end
      end else if (m_age == 0) begin
         m_age = 1;
         m_bin = m_pend_bin;
      end else if (rd) begin
         m_active = 1'b0;
         hs_count++;
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   // One clock: capture inputs, advance model at the edge, compare 1 time unit later.
   task automatic step();
      logic [3:0]  r;
      logic [15:0] g;
      logic        rd;
      r  = req;
      g  = gray_in;
      rd = out_ready;
      @(posedge clk);
      model_edge(r, g, rd);
      #1;
      for (int i = 0; i < 4; i++) if (bit_of(gnt, i)) dut_grants.push_back(i);
      check_val("gnt", 32'(gnt), 32'(m_gnt));
      check_val("out_valid", 32'(out_valid), 32'(m_active && m_age == 1));
      check_val("busy", 32'(busy), 32'(m_active));
      check_val("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
      if (m_active && m_age == 1) begin
         check_val("out_bin", 32'(out_bin), 32'(m_bin));
         check_val("out_id", 32'(out_id), 32'(m_id));
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = 4'd0;
      #2;
      check_val("rst_gnt", 32'(gnt), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_bin", 32'(out_bin), 32'd0);
      check_val("rst_out_id", 32'(out_id), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_conv_cnt", 32'(conv_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int n);
      req       = 4'd0;
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [3:0] ex_g [3];
      logic [3:0] ex_b [3];
      int         exp_order [5];
      ex_g = '{4'h8, 4'hB, 4'h3};
      ex_b = '{4'hF, 4'hD, 4'h2};
      exp_order = '{0, 1, 2, 3, 0};

      rst_n     = 1'b0;
      req       = 4'd0;
      gray_in   = 16'd0;
      out_ready = 1'b0;
      model_reset();
      apply_reset();

      // single request on requester 0
      req       = 4'b0001;
      gray_in   = 16'h0006;
      out_ready = 1'b1;
      step();
      check_val("single_gnt", 32'(gnt), 32'h1);
      req = 4'd0;
      step();
      check_val("single_valid", 32'(out_valid), 32'd1);
      check_val("single_bin", 32'(out_bin), 32'h4);
      check_val("single_id", 32'(out_id), 32'd0);
      step();
      check_val("single_cnt", 32'(conv_cnt), 32'd1);

      // full contention straight after reset
      apply_reset();
      dut_grants.delete();
      req       = 4'b1111;
      gray_in   = 16'hC93A;
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) step();
      check_val("rr_count", 32'(dut_grants.size()), 32'd5);
      for (int i = 0; i < 5 && i < dut_grants.size(); i++)
         check_val("rr_order", 32'(dut_grants[i]), 32'(exp_order[i]));
      drain(6);

      // back-pressure with competing requests pending
      req       = 4'b0100;
      gray_in   = 16'h0D00;
      out_ready = 1'b0;
      step();
      req = 4'b1011;
      step();
      for (int i = 0; i < 5; i++) step();
      check_val("bp_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      step();
      check_val("bp_release", 32'(out_valid), 32'd0);
      drain(10);

      // every Gray code through requester 2
      for (int c = 0; c < 16; c++) begin
         logic [3:0] cw;
         cw        = 4'(c);
         gray_in   = {4'h0, cw, 8'h00};
         req       = 4'b0100;
         out_ready = 1'b1;
         step();
         req = 4'd0;
         step();
         for (int j = 0; j < 3; j++)
            if (cw == ex_g[j]) check_val("gray_example", 32'(out_bin), 32'(ex_b[j]));
         step();
      end

      // random traffic; requesters hold until granted
      for (int n = 0; n < 400; n++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            logic [3:0]  bm;
            logic [15:0] fm;
            bm = 4'd1 << i;
            fm = 16'hF << (4 * i);
            if ((m_gnt & bm) != 4'd0) begin
               req = req & ~bm;
            end else if ((req & bm) == 4'd0 && $urandom_range(3) == 0) begin
               req     = req | bm;
               gray_in = (gray_in & ~fm) | (16'($urandom_range(15)) << (4 * i));
            end
         end
         out_ready = ($urandom_range(2) != 0);
      end
      drain(10);

      // reset while holding a result in OUT
      req       = 4'b0010;
      gray_in   = 16'h00F0;
      out_ready = 1'b0;
      step();
      req = 4'd0;
      step();
      check_val("mid_bin", 32'(out_bin), 32'hA);
      #2;
      apply_reset();
      req       = 4'b1001;
      out_ready = 1'b1;
      step();
      check_val("post_rst_gnt0", 32'(gnt), 32'h1);
      req = 4'b1000;
      step();
      step();
      for (int i = 0; i < 3; i++) step();
      check_val("post_rst_id3", 32'(out_id), 32'd3);
      drain(4);

      // counter saturation
      apply_reset();
      req       = 4'b0001;
      gray_in   = 16'h0005;
      out_ready = 1'b1;
      for (int s = 0; s < 2000 && hs_count < 260; s++) step();
      check_val("sat_reached", 32'(hs_count >= 260), 32'd1);
      check_val("sat_cnt", 32'(conv_cnt), 32'd255);
      for (int s = 0; s < 20; s++) step();
      check_val("sat_hold", 32'(conv_cnt), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
